// File: rtl/ppwm_pkg.sv
// rtl/ppwm_pkg.sv - shared encodings for the PPWM instruction executors
//
// Purpose: opcode, operand-selector, control-subcode and executor-state
// encodings used by the single- and multi-channel PPWM executors.
// Ports: none (package).

package ppwm_pkg;

  // Opcode in instr[2:0]
  typedef enum logic [2:0] {
    CMD_CTRL   = 3'd0,
    CMD_SET    = 3'd1,
    CMD_ARITH  = 3'd2,
    CMD_SHIFT  = 3'd3,
    CMD_JUMP   = 3'd4,
    CMD_BRANCH = 3'd5,
    CMD_CMP    = 3'd6,
    CMD_MV     = 3'd7
  } command_e;

  // Destination register in instr[3]
  typedef enum logic {
    TGT_PWM = 1'b0,
    TGT_REG = 1'b1
  } target_e;

  // CMP operand pair in instr[5:3]; flag <= (first < second), unsigned
  typedef enum logic [2:0] {
    CMP_GCNTL_PWM = 3'd0,
    CMP_GCNTL_REG = 3'd1,
    CMP_GCNTH_PWM = 3'd2,
    CMP_GCNTH_REG = 3'd3,
    CMP_PWM_REG   = 3'd4
  } cmp_args_e;

  // MV selector in instr[5:3]; named <destination>_<source>
  typedef enum logic [2:0] {
    MV_PWM_REG   = 3'd0,
    MV_REG_PWM   = 3'd1,
    MV_PWM_GCNTL = 3'd2,
    MV_REG_GCNTL = 3'd3,
    MV_PWM_GCNTH = 3'd4,
    MV_REG_GCNTH = 3'd5
  } mv_args_e;

  // CTRL subcode in instr[6:3]
  typedef enum logic [3:0] {
    CTRL_NOP    = 4'd0,
    CTRL_WAIT   = 4'd1,
    CTRL_POL0   = 4'd2,
    CTRL_POL1   = 4'd3,
    CTRL_HALT   = 4'd4,
    CTRL_TOGGLE = 4'd5
  } ctrl_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWait = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ppwm_ch_ctx.sv
// rtl/ppwm_ch_ctx.sv - one channel's executor context, start/overrun logic and PWM pin
//
// Purpose: holds PC, state, compare flag, register, PWM value and polarity for
// one channel. Loads the shared execute result only when this channel owns the
// current slot and is executing.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, ovr_clr    period start request, overrun clear
//   sel               this channel owns the current slot
//   gcnt_l            low COUNTER_WIDTH bits of the global counter
//   nxt_*             next context computed by the shared execute path
//   pc, flag, reg_val, pwm_value, pol   current context
//   busy, overrun, pwm_pin              status and registered pin

module ppwm_ch_ctx
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 10,
  parameter int PC_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ovr_clr,
  input  logic                     sel,
  input  logic [COUNTER_WIDTH-1:0] gcnt_l,
  input  logic [PC_WIDTH-1:0]      nxt_pc,
  input  ex_state_e                nxt_state,
  input  logic                     nxt_flag,
  input  logic [COUNTER_WIDTH-1:0] nxt_reg,
  input  logic [COUNTER_WIDTH-1:0] nxt_pwm,
  input  logic                     nxt_pol,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     flag,
  output logic [COUNTER_WIDTH-1:0] reg_val,
  output logic [COUNTER_WIDTH-1:0] pwm_value,
  output logic                     pol,
  output logic                     busy,
  output logic                     overrun,
  output logic                     pwm_pin
);

  ex_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      pc        <= '0;
      flag      <= 1'b0;
      reg_val   <= '0;
      pwm_value <= '0;
      pol       <= 1'b0;
      overrun   <= 1'b0;
      pwm_pin   <= 1'b0;
    end else begin
      pwm_pin <= (gcnt_l < pwm_value) ^ pol;

      // A start while executing is dropped but recorded; it beats a clear.
      if (start && (state == StExec)) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        StExec: begin
          if (sel) begin
            state     <= nxt_state;
            pc        <= nxt_pc;
            flag      <= nxt_flag;
            reg_val   <= nxt_reg;
            pwm_value <= nxt_pwm;
            pol       <= nxt_pol;
          end
        end
        default: begin
          // Idle and Wait both resume from the held PC.
          if (start) begin
            state <= StExec;
          end
        end
      endcase
    end
  end

  assign busy = (state == StExec);

endmodule

// File: rtl/ppwm_ex_mc.sv
// rtl/ppwm_ex_mc.sv - multi-channel time-sliced PPWM instruction executor
//
// Purpose: runs NUM_CH PWM programs from one shared instruction store. A slot
// pointer rotates every cycle; the owning channel's context is muxed into a
// single decode/execute path and written back if that channel is executing.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_i, ovr_clr_i    per-channel start request, overrun clear
//   global_counter_i      free-running global counter
//   ch_o, pc_o            fetch address (slot channel, its PC)
//   instr_i               instruction at (ch_o, pc_o), same cycle
//   pwm_value_o           per-channel PWM values, channel c at [c*CW +: CW]
//   output_polarity_o, pwm_o, busy_o, overrun_o   per-channel status/pins

module ppwm_ex_mc
  import ppwm_pkg::*;
#(
  parameter int NUM_CH               = 4,
  parameter int COUNTER_WIDTH        = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20,
  parameter int INSTR_WIDTH          = 7,
  parameter int PC_WIDTH             = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               start_i,
  input  logic [NUM_CH-1:0]               ovr_clr_i,
  input  logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_i,
  output logic [CH_W-1:0]                 ch_o,
  output logic [PC_WIDTH-1:0]             pc_o,
  input  logic [INSTR_WIDTH-1:0]          instr_i,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] pwm_value_o,
  output logic [NUM_CH-1:0]               output_polarity_o,
  output logic [NUM_CH-1:0]               pwm_o,
  output logic [NUM_CH-1:0]               busy_o,
  output logic [NUM_CH-1:0]               overrun_o
);

  localparam int CW = COUNTER_WIDTH;

  logic [CH_W-1:0] slot_q;

  logic [PC_WIDTH-1:0] pc_a   [NUM_CH];
  logic                flag_a [NUM_CH];
  logic [CW-1:0]       reg_a  [NUM_CH];
  logic [CW-1:0]       pwm_a  [NUM_CH];
  logic                pol_a  [NUM_CH];

  logic [PC_WIDTH-1:0] cur_pc;
  logic                cur_flag;
  logic [CW-1:0]       cur_reg;
  logic [CW-1:0]       cur_pwm;
  logic                cur_pol;

  logic [PC_WIDTH-1:0] nxt_pc;
  ex_state_e           nxt_state;
  logic                nxt_flag;
  logic [CW-1:0]       nxt_reg;
  logic [CW-1:0]       nxt_pwm;
  logic                nxt_pol;

  // Instruction fields
  command_e            op;
  target_e             target;
  ctrl_e               ctrl;
  cmp_args_e           cmp_args;
  mv_args_e            mv_args;
  logic [2:0]          imm3;
  logic [PC_WIDTH-1:0] offset;
  logic [2:0]          sh_amt;
  logic [CW-1:0]       imm_sext;
  logic [CW-1:0]       gcnt_l;
  logic [CW-1:0]       gcnt_h;
  logic [CW-1:0]       cur_tgt;
  logic [CW-1:0]       res;
  logic                tgt_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (slot_q == CH_W'(NUM_CH - 1)) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + CH_W'(1);
    end
  end

  assign cur_pc   = pc_a[slot_q];
  assign cur_flag = flag_a[slot_q];
  assign cur_reg  = reg_a[slot_q];
  assign cur_pwm  = pwm_a[slot_q];
  assign cur_pol  = pol_a[slot_q];

  assign ch_o = slot_q;
  assign pc_o = cur_pc;

  assign op       = command_e'(instr_i[2:0]);
  assign target   = target_e'(instr_i[3]);
  assign ctrl     = ctrl_e'(instr_i[6:3]);
  assign cmp_args = cmp_args_e'(instr_i[5:3]);
  assign mv_args  = mv_args_e'(instr_i[5:3]);
  assign imm3     = instr_i[6:4];
  assign offset   = PC_WIDTH'(instr_i[6:3]);
  assign sh_amt   = {1'b0, imm3[2:1]} + 3'd1;
  assign imm_sext = {{(CW-3){imm3[2]}}, imm3};
  assign gcnt_l   = global_counter_i[CW-1:0];
  assign gcnt_h   = CW'(global_counter_i[GLOBAL_COUNTER_WIDTH-1:CW]);
  assign cur_tgt  = (target == TGT_REG) ? cur_reg : cur_pwm;

  always_comb begin
    // End of program only changes the state; a jump at pc=='1 keeps its target.
    nxt_pc    = cur_pc + PC_WIDTH'(1);
    nxt_state = (cur_pc == '1) ? StIdle : StExec;
    nxt_flag  = cur_flag;
    nxt_reg   = cur_reg;
    nxt_pwm   = cur_pwm;
    nxt_pol   = cur_pol;
    res       = cur_tgt;
    tgt_wr    = 1'b0;

    case (op)
      CMD_CTRL: begin
        case (ctrl)
          CTRL_WAIT: begin
            nxt_state = StWait;
            nxt_pc    = cur_pc;
          end
          CTRL_POL0:   nxt_pol = 1'b0;
          CTRL_POL1:   nxt_pol = 1'b1;
          CTRL_HALT: begin
            nxt_state = StIdle;
            nxt_pc    = '0;
          end
          CTRL_TOGGLE: nxt_pol = ~cur_pol;
          default: ;
        endcase
      end
      CMD_SET: begin
        res    = CW'(imm3);
        tgt_wr = 1'b1;
      end
      CMD_ARITH: begin
        res    = cur_tgt + imm_sext;
        tgt_wr = 1'b1;
      end
      CMD_SHIFT: begin
        res    = imm3[0] ? (cur_tgt << sh_amt) : (cur_tgt >> sh_amt);
        tgt_wr = 1'b1;
      end
      CMD_JUMP: nxt_pc = cur_pc + offset;
      CMD_BRANCH: begin
        if (cur_flag) begin
          nxt_pc = cur_pc + offset;
        end
      end
      CMD_CMP: begin
        case (cmp_args)
          CMP_GCNTL_PWM: nxt_flag = (gcnt_l < cur_pwm);
          CMP_GCNTL_REG: nxt_flag = (gcnt_l < cur_reg);
          CMP_GCNTH_PWM: nxt_flag = (gcnt_h < cur_pwm);
          CMP_GCNTH_REG: nxt_flag = (gcnt_h < cur_reg);
          CMP_PWM_REG:   nxt_flag = (cur_pwm < cur_reg);
          default:       nxt_flag = 1'b0;
        endcase
      end
      CMD_MV: begin
        case (mv_args)
          MV_PWM_REG:   nxt_pwm = cur_reg;
          MV_REG_PWM:   nxt_reg = cur_pwm;
          MV_PWM_GCNTL: nxt_pwm = gcnt_l;
          MV_REG_GCNTL: nxt_reg = gcnt_l;
          MV_PWM_GCNTH: nxt_pwm = gcnt_h;
          MV_REG_GCNTH: nxt_reg = gcnt_h;
          default: ;
        endcase
      end
      default: ;
    endcase

    if (tgt_wr) begin
      if (target == TGT_REG) begin
        nxt_reg = res;
      end else begin
        nxt_pwm = res;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ppwm_ch_ctx #(
      .COUNTER_WIDTH(CW),
      .PC_WIDTH     (PC_WIDTH)
    ) u_ctx (
      .clk      (clk),
      .rst      (rst),
      .start    (start_i[c]),
      .ovr_clr  (ovr_clr_i[c]),
      .sel      (slot_q == CH_W'(c)),
      .gcnt_l   (gcnt_l),
      .nxt_pc   (nxt_pc),
      .nxt_state(nxt_state),
      .nxt_flag (nxt_flag),
      .nxt_reg  (nxt_reg),
      .nxt_pwm  (nxt_pwm),
      .nxt_pol  (nxt_pol),
      .pc       (pc_a[c]),
      .flag     (flag_a[c]),
      .reg_val  (reg_a[c]),
      .pwm_value(pwm_a[c]),
      .pol      (pol_a[c]),
      .busy     (busy_o[c]),
      .overrun  (overrun_o[c]),
      .pwm_pin  (pwm_o[c])
    );

    assign pwm_value_o[c*CW +: CW] = pwm_a[c];
    assign output_polarity_o[c]    = pol_a[c];
  end

endmodule
